// File: rtl/uart_tx_flow_if.sv
// Byte handshake between a data source and the UART transmitter.
// The source drives data/valid; the transmitter answers with ready.
interface uart_tx_flow_if #(
   parameter int DATA_BITS = 8
) ();
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/uart_tx_flow.sv
// UART transmitter with byte FIFO and CTS/RTS hardware flow control.
// Frames: start, data LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_flow #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst_,
   uart_tx_flow_if.slave               tx,
   input  logic                        cts_n,
   output logic                        sout_data,
   output logic                        rts_n,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP
   } state_t;

   state_t state, next_state;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [BW-1:0]        baud;
   logic [2:0]           idx;
   logic [7:0]           shift;
   logic                 cts_s1, cts_s2, cts_ok;
   logic                 push, pop, tc, par;
   logic                 sout_d, busy_d, rts_d;

   assign cts_ok      = !cts_s2;
   assign tx.tx_ready = (fifo_count != CW'(FIFO_DEPTH));
   assign push        = tx.tx_valid && tx.tx_ready;
   assign pop         = (state == IDLE) && (fifo_count != '0) && cts_ok;
   assign tc          = (baud == '0);
   assign par         = (^shift[DATA_BITS-1:0]) ^ (PARITY_ODD != 0);

   // Two-flop synchroniser for the asynchronous clear-to-send input.
   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         cts_s1 <= 1'b1;
         cts_s2 <= 1'b1;
      end else begin
         cts_s1 <= cts_n;
         cts_s2 <= cts_s1;
      end
   end

   // FIFO storage; contents are don't-care until a pointer reaches them.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= tx.tx_data;
   end

   // FIFO pointers and occupancy; push+pop together leaves count unchanged.
   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      fifo_count <= fifo_count + CW'(1);
         else if (pop && !push) fifo_count <= fifo_count - CW'(1);
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) state <= IDLE;
      else      state <= next_state;
   end

   // FSM next-state: each bit period ends on baud terminal count.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:   if (pop) next_state = START;
         START:  if (tc) next_state = DATA;
         DATA:   if (tc && idx == LAST_DATA)
                    next_state = (PARITY_EN != 0) ? PARITY : STOP;
         PARITY: if (tc) next_state = STOP;
         STOP:   if (tc && idx == LAST_STOP) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Shift register, baud down-counter and bit index within a state.
   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         baud  <= '0;
         idx   <= '0;
         shift <= '0;
      end else if (pop) begin
         shift <= 8'(mem[rd_ptr]);
         baud  <= BAUD_MAX;
         idx   <= '0;
      end else if (state != IDLE) begin
         if (tc) begin
            baud <= BAUD_MAX;
            idx  <= (next_state != state) ? 3'd0 : idx + 3'd1;
         end else begin
            baud <= baud - BW'(1);
         end
      end
   end

   // FSM outputs, computed here and registered below.
   always_comb begin
      sout_d = 1'b1;
      unique case (state)
         START:   sout_d = 1'b0;
         DATA:    sout_d = shift[idx];
         PARITY:  sout_d = par;
         default: sout_d = 1'b1;
      endcase
      busy_d = (next_state != IDLE);
      rts_d  = !((fifo_count != '0) || busy);
   end

   // Output registers; reset forces the line high without a clock.
   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         sout_data <= 1'b1;
         busy      <= 1'b0;
         rts_n     <= 1'b1;
      end else begin
         sout_data <= sout_d;
         busy      <= busy_d;
         rts_n     <= rts_d;
      end
   end

endmodule

// File: doc/uart_tx_flow.md
Name: uart_tx_flow

Overview:
- Serial UART transmitter that drives the DUT-facing serial line monitored by the UART agent's `sout_data` / `rts_n` signals.
- Accepts bytes on a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte as start, data (LSB first), optional parity and stop bits.
- Honours CTS hardware flow control: a new frame starts only when `cts_n` is asserted low.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal range ≥ 2.
- DATA_BITS, 8: data bits per frame; legal range 5–8.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.
- FIFO_DEPTH, 4: byte FIFO entries; must be a power of 2, ≥ 2.

Ports:
- clk, input, 1: system clock.
- rst_, input, 1: reset.
- tx_data, input, DATA_BITS: byte to send.
- tx_valid, input, 1: tx_data valid.
- tx_ready, output, 1: FIFO can accept; high when FIFO not full.
- cts_n, input, 1: clear-to-send, active low, asynchronous to clk.
- sout_data, output, 1: serial line; idles high.
- rts_n, output, 1: request-to-send; low while FIFO non-empty or a frame is in progress.
- busy, output, 1: high while the FSM is not in IDLE.
- fifo_count, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Behaviour:
- Clocking and reset:
  - Single clock domain `clk`.
  - Reset is asynchronous and active-high. The port is named `rst_` per codebase convention; its polarity is active-high regardless of the name.
  - Reset values: sout_data=1, rts_n=1, busy=0, tx_ready=1, fifo_count=0. FIFO pointers, FSM state, bit and baud counters all cleared.
- Reset mid-frame: the line returns high immediately (asynchronously) and FIFO contents are discarded.
- Handshake:
  - A byte is written when tx_valid && tx_ready at a rising edge.
  - tx_ready = (fifo_count != FIFO_DEPTH), combinational from registered count.
  - Writes while full are ignored; the source must hold data.
  - A simultaneous push and pop while full is not possible, because tx_ready is low when full.
  - A simultaneous push and pop at any other occupancy leaves fifo_count unchanged.
- CTS synchronisation: cts_n passes through a 2-FF synchroniser; `cts_ok` = synchronised value == 0.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
  - IDLE: sout_data=1. If FIFO non-empty and cts_ok: pop the head into the shift register, go to START, load baud counter.
  - START: sout_data=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: sout_data = shift[idx] for CLKS_PER_BIT cycles each. After DATA_BITS bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY: bit value = XOR of data bits, XOR PARITY_ODD; held for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: sout_data=1 for STOP_BITS × CLKS_PER_BIT cycles. Then return to IDLE; the next frame may start on the following cycle (IDLE lasts ≥ 1 cycle between frames).
- Timing:
  - sout_data falls on the cycle after the pop decision in IDLE.
  - Latency from a write into an empty FIFO with idle FSM and cts_ok stable: start bit visible 2 cycles after the accepting edge.
- Flow control:
  - cts_n deassertion mid-frame does not abort; the current frame completes and the FSM holds in IDLE until cts_ok.
  - rts_n = !(fifo_count != 0 || busy), registered.
- Baud counter: counts CLKS_PER_BIT-1 down to 0; the bit advances on terminal count.
- Frame length: (1 + DATA_BITS + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles.

Test Plan:
- Single byte, CLKS_PER_BIT=4, defaults, cts_n=0:
  - Stimulus: write 0x55.
  - Required response: sout_data low 4 cycles from 2 cycles after the write; then bits 1,0,1,0,1,0,1,0 for 4 cycles each; then high 4 cycles. Total 40 cycles; busy high for 40 cycles.
- Parity, PARITY_EN=1:
  - Even parity, byte 0x07 → parity bit 1.
  - PARITY_ODD=1, byte 0x07 → parity bit 0.
  - Frame is 44 cycles at CLKS_PER_BIT=4.
- FIFO full:
  - Stimulus: cts_n=1; write 5 bytes with tx_valid held.
  - Required response: first 4 accepted; tx_ready=0; fifo_count=4; rts_n=0; sout_data stays 1.
  - Then drop cts_n: 4 back-to-back frames emitted in order, each separated by exactly 1 idle cycle.
- CTS deassert mid-frame:
  - Stimulus: two bytes queued; raise cts_n during the DATA bit 3 of frame 1.
  - Required response: frame 1 completes intact; the line stays high until cts_n=0 is synchronised (2 cycles); frame 2 then starts.
- Reset mid-frame:
  - Stimulus: assert rst_ during the DATA state.
  - Required response: sout_data=1 and fifo_count=0 with no clock edge; after release, no residual frame is sent.
- Simultaneous push and pop:
  - Stimulus: write a byte on the same edge as an IDLE pop, with occupancy 2.
  - Required response: fifo_count stays 2; byte order is preserved.
